// File: rtl/i2c_byte_master.sv
// Byte-level I2C write engine: START/RSTART framing, 8 data bits MSB first, ACK slot, optional STOP.
// Optional feature macro: I2C_ACK_CHECK_EN (open-drain sda, ACK sampling, ack_err reporting).
//
// state  | meaning
// IDLE   | bus free, sck=1 sda=1, ready for a command
// RSTART | repeated-START setup: R0 sda=1 sck=0, R1 sck=1
// START  | S0 sda falls with sck high, S1 sck falls
// BIT    | one data bit over four quarters, sck high in q1/q2
// ACK    | ninth clock, sda released or driven low
// STOP   | P0 sda=0 sck=0, P1 sck=1, P2 sda rises
// HELD   | bus owned between bytes, sck=0 sda=0, ready for a command
module i2c_byte_master #(
    parameter int CLK_HZ = 27_000_000,
    parameter int I2C_HZ = 400_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic       ack_err,
    output logic       sck,
    inout  wire        sda
);

    localparam int DIV = CLK_HZ / (4 * I2C_HZ);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("i2c_byte_master: CLK_HZ/(4*I2C_HZ) must be at least 1");
    end

`ifdef I2C_ACK_CHECK_EN
    localparam logic ACK_LVL = 1'b1;
`else
    localparam logic ACK_LVL = 1'b0;
`endif

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RSTART = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] BIT    = 3'd3;
    localparam logic [2:0] ACK    = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;
    localparam logic [2:0] HELD   = 3'd6;

    logic [2:0]    state_q, state_nx;
    logic [1:0]    qtr_q, qtr_nx;
    logic [2:0]    bit_cnt_q, bit_cnt_nx;
    logic [7:0]    shreg_q, shreg_nx;
    logic          stop_q, stop_nx;
    logic [DW-1:0] div_q, div_nx;
    logic          sck_q, sda_q, done_q, done_nx;
    logic          busy, tick, accept;

    function automatic logic sck_of(input logic [2:0] st, input logic [1:0] q);
        logic r;
        r = 1'b1;
        case (st)
            RSTART:   r = (q == 2'd1);
            START:    r = (q == 2'd0);
            BIT, ACK: r = (q == 2'd1) || (q == 2'd2);
            STOP:     r = (q != 2'd0);
            HELD:     r = 1'b0;
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic sda_of(input logic [2:0] st, input logic [1:0] q, input logic b);
        logic r;
        r = 1'b1;
        case (st)
            START:   r = 1'b0;
            BIT:     r = b;
            ACK:     r = ACK_LVL;
            STOP:    r = (q == 2'd2);
            HELD:    r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign cmd_ready = (state_q == IDLE) || (state_q == HELD);
    assign busy      = !cmd_ready;
    assign tick      = busy && (div_q == DIV_LAST);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nx   = state_q;
        qtr_nx     = qtr_q;
        bit_cnt_nx = bit_cnt_q;
        shreg_nx   = shreg_q;
        stop_nx    = stop_q;
        done_nx    = 1'b0;
        div_nx     = (busy && !tick) ? div_q + DW'(1) : '0;
        if (accept) begin
            shreg_nx   = cmd_data;
            stop_nx    = cmd_stop;
            qtr_nx     = 2'd0;
            bit_cnt_nx = 3'd7;
            div_nx     = '0;
            // START is mandatory from a free bus; cmd_start only matters while holding it
            if (state_q == IDLE)
                state_nx = START;
            else if (cmd_start)
                state_nx = RSTART;
            else
                state_nx = BIT;
        end else if (tick) begin
            qtr_nx = qtr_q + 2'd1;
            case (state_q)
                RSTART: if (qtr_q == 2'd1) begin
                    state_nx = START;
                    qtr_nx   = 2'd0;
                end
                START: if (qtr_q == 2'd1) begin
                    state_nx = BIT;
                    qtr_nx   = 2'd0;
                end
                BIT: if (qtr_q == 2'd3) begin
                    shreg_nx = {shreg_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0)
                        state_nx = ACK;
                    else
                        bit_cnt_nx = bit_cnt_q - 3'd1;
                end
                ACK: if (qtr_q == 2'd3) begin
                    state_nx = stop_q ? STOP : HELD;
                    done_nx  = !stop_q;
                end
                STOP: if (qtr_q == 2'd2) begin
                    state_nx = IDLE;
                    qtr_nx   = 2'd0;
                    done_nx  = 1'b1;
                end
                default: begin
                    state_nx = IDLE;
                    qtr_nx   = 2'd0;
                end
            endcase
        end
    end

    // Pins are registered from the next-state decode so they change cleanly on the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            qtr_q     <= 2'd0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
            stop_q    <= 1'b0;
            div_q     <= '0;
            sck_q     <= 1'b1;
            sda_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            qtr_q     <= qtr_nx;
            bit_cnt_q <= bit_cnt_nx;
            shreg_q   <= shreg_nx;
            stop_q    <= stop_nx;
            div_q     <= div_nx;
            sck_q     <= sck_of(state_nx, qtr_nx);
            sda_q     <= sda_of(state_nx, qtr_nx, shreg_nx[7]);
            done_q    <= done_nx;
        end
    end

    assign sck  = sck_q;
    assign done = done_q;

`ifdef I2C_ACK_CHECK_EN
    logic ack_smp_q, ack_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_smp_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            if (tick && (state_q == ACK) && (qtr_q == 2'd2))
                ack_smp_q <= sda;
            if (accept)
                ack_err_q <= 1'b0;
            else if (done_nx)
                ack_err_q <= ack_smp_q;
        end
    end

    assign ack_err = ack_err_q;
    assign sda     = sda_q ? 1'bz : 1'b0;
`else
    assign ack_err = 1'b0;
    assign sda     = sda_q;
`endif

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed/randomised bench for i2c_byte_master: a bus monitor decodes START/STOP/bits from the pins
// and each byte is compared with the event sequence and latency expected from the framing rules.
module tb_i2c_byte_master;

    localparam int CLK_HZ = 27_000_000;
    localparam int I2C_HZ = 400_000;
    localparam int DIV    = CLK_HZ / (4 * I2C_HZ);
    localparam int EV_START = 2;
    localparam int EV_STOP  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, done, ack_err, sck;
    wire        sda;

    int checks = 0;
    int errors = 0;

    int  evq[$];
    int  glitches = 0;
    int  rises = 0;
    int  acc_id = 0;
    int  seen_acc = 0;
    bit  pending = 0;
    bit  sck_p = 1, sda_p = 1;
    bit  slv_drv = 0;
    bit  slave_nack = 0;
    bit  bus_held = 0;

    i2c_byte_master #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_data(cmd_data),
        .done(done), .ack_err(ack_err), .sck(sck), .sda(sda)
    );

`ifdef I2C_ACK_CHECK_EN
    pullup (sda);
    assign sda = slv_drv ? 1'b0 : 1'bz;
`endif

    always #5 clk = ~clk;

    function automatic bit sda_lvl();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    // Bus monitor: bits on sck rise, START/STOP on sda edges while sck high
    always @(negedge clk) begin
        bit sv, dv;
        sv = (sck === 1'b1);
        dv = sda_lvl();
        if (acc_id != seen_acc) begin
            seen_acc = acc_id;
            rises = 0;
        end
        if (!rst_n) begin
            pending = 0;
            slv_drv = 0;
        end else begin
            if (sv != sck_p && dv != sda_p) begin
                glitches++;
            end else if (!sck_p && sv) begin
                evq.push_back(int'(dv));
                pending = 1;
                rises++;
            end else if (sck_p && !sv) begin
                pending = 0;
                if (rises == 8) slv_drv = !slave_nack;
                else if (rises >= 9) slv_drv = 0;
            end else if (sck_p && sv && dv != sda_p) begin
                if (pending && evq.size() > 0) void'(evq.pop_back());
                pending = 0;
                evq.push_back(dv ? EV_STOP : EV_START);
                if (!dv) rises = 0;
            end
        end
        sck_p = sv;
        sda_p = dv;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input bit st, input bit sp, input bit nack, input bit hold_valid);
        int expq[$];
        int lat_exp, n, ready_seen, base;
        bit got_done, issue_st, rst_seq, ack_bit, same;
        issue_st = !bus_held || st;
        rst_seq  = bus_held && st;
`ifdef I2C_ACK_CHECK_EN
        ack_bit = nack;
`else
        ack_bit = 0;
`endif
        lat_exp = DIV * (36 + (issue_st ? 2 : 0) + (rst_seq ? 2 : 0) + (sp ? 3 : 0));
        if (issue_st) expq.push_back(EV_START);
        for (int i = 7; i >= 0; i--) expq.push_back(int'(d[i]));
        expq.push_back(int'(ack_bit));
        if (sp) expq.push_back(EV_STOP);

        @(negedge clk);
        cmd_valid = 1; cmd_data = d; cmd_start = st; cmd_stop = sp;
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        acc_id++;
        slave_nack = nack;
        base = evq.size();
        chk("ack_err_cleared_on_accept", ack_err, 0);
        if (!hold_valid) cmd_valid = 0;
        n = 0; got_done = 0; ready_seen = 0;
        while (n < 3000 && !got_done) begin
            if (hold_valid) begin
                cmd_data = 8'($urandom); cmd_start = 1'($urandom); cmd_stop = 1'($urandom);
            end
            @(posedge clk);
            n++;
            #1;
            if (done === 1'b1) got_done = 1;
            else if (cmd_ready !== 1'b0) ready_seen++;
        end
        cmd_valid = 0;
        chk("done_latency", n, lat_exp);
        chk("ready_low_while_busy", ready_seen, 0);
        chk("event_count", evq.size() - base, expq.size());
        same = (evq.size() - base == expq.size());
        if (same) for (int i = 0; i < expq.size(); i++) if (evq[base + i] != expq[i]) same = 0;
        chk("event_sequence", same, 1);
        chk("ack_err_at_done", ack_err, ack_bit);
        chk("ready_at_done", cmd_ready, 1);
        chk("sck_after_byte", sck, sp ? 1 : 0);
        chk("sda_after_byte", sda_lvl(), sp ? 1 : 0);
        bus_held = !sp;
    endtask

    initial begin
        logic [7:0] d;
        int dn;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", cmd_ready, 1);
        chk("reset_sck", sck, 1);
        chk("reset_sda", sda_lvl(), 1);
        chk("reset_done", done, 0);
        chk("reset_ack_err", ack_err, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(posedge clk);

        xfer(8'h78, 1, 1, 0, 0);
        repeat (5) @(posedge clk);
        xfer(8'h00, 0, 0, 0, 0);
        xfer(8'hAF, 0, 1, 0, 0);

        xfer(8'($urandom), 1, 1, 1, 0);
        xfer(8'($urandom), 1, 0, 0, 0);
        xfer(8'($urandom), 1, 0, 1, 0);
        xfer(8'($urandom), 1, 1, 0, 0);

        for (int i = 0; i < 8; i++) begin
            xfer(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(20, 1)) @(posedge clk);
        end

        xfer(8'($urandom), 1, 0, 0, 1);
        xfer(8'($urandom), 0, 1, 0, 1);

        if (bus_held) xfer(8'h5A, 0, 1, 0, 0);
        repeat (4) @(posedge clk);
        d = 8'($urandom);
        @(negedge clk);
        cmd_valid = 1; cmd_data = d; cmd_start = 1; cmd_stop = 1;
        @(posedge clk);
        #1;
        acc_id++;
        cmd_valid = 0;
        repeat (10 * DIV) @(posedge clk);
        #1;
        chk("q10_sck", sck, 0);
        chk("q10_sda", sda_lvl(), d[5]);
        #2;
        rst_n = 0;
        #1;
        chk("midbyte_reset_sck", sck, 1);
        chk("midbyte_reset_sda", sda_lvl(), 1);
        chk("midbyte_reset_ready", cmd_ready, 1);
        chk("midbyte_reset_done", done, 0);
        dn = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) dn++;
        end
        @(negedge clk);
        rst_n = 1;
        bus_held = 0;
        repeat (2 * DIV) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || sck !== 1'b1) dn++;
        end
        chk("no_done_after_reset", dn, 0);

        xfer(8'($urandom), 0, 0, 0, 0);
        xfer(8'($urandom), 1, 1, 1, 0);

        chk("sda_sck_same_edge", glitches, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
